dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_BUS_WIDTH, default 13, the data memory address width.
REQ-002 The block SHALL have parameter DATABUS_SIZE, default 24, the data memory word width.
REQ-003 The block SHALL have port clk  in  1  single clock; all state changes on posedge.
REQ-004 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have port pN_req_valid  in  1  request pending on port N (N = 0,1), held until accepted.
REQ-006 The block SHALL have port pN_req_we  in  1  1 = write, 0 = read.
REQ-007 The block SHALL have port pN_req_addr  in  ADDR_BUS_WIDTH  request address.
REQ-008 The block SHALL have port pN_req_wdata  in  DATABUS_SIZE  write data.
REQ-009 The block SHALL have port pN_req_ready  out  1  request accepted this cycle.
REQ-010 The block SHALL have port pN_rsp_valid  out  1  one-cycle completion pulse.
REQ-011 The block SHALL have port pN_rsp_rdata  out  DATABUS_SIZE  read result; 0 for writes.
REQ-012 The block SHALL have port mem_read, mem_write  out  1 each  data memory strobes.
REQ-013 The block SHALL have port mem_address  out  ADDR_BUS_WIDTH  data memory address.
REQ-014 The block SHALL have port mem_write_data  out  DATABUS_SIZE  data memory write data.
REQ-015 The block SHALL have port mem_read_data  in  DATABUS_SIZE  combinational read data from memory.
REQ-016 The block SHALL have port busy  out  1  high in any state other than IDLE.
REQ-017 The block SHALL have port pN_grant_cnt  out  16  saturating count of accepted requests per port.

Function
REQ-018 FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS on acceptance, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-019 In IDLE with any pN_req_valid high, exactly one pN_req_ready SHALL be asserted combinationally for the winner; no ready outside IDLE.
REQ-020 On acceptance, winner id, we, addr, wdata SHALL be latched; requester may change inputs afterwards.
REQ-021 In ACCESS, mem_address/mem_write_data SHALL come from the latch; mem_write = we, mem_read = !we; both strobes 0 in IDLE and RESP.
REQ-022 Memory write SHALL occur at the posedge ending ACCESS; mem_read_data SHALL be captured into the rdata register at that same edge (reads only; writes capture 0).
REQ-023 In RESP, pN_rsp_valid SHALL pulse for exactly one cycle on the latched port only, with pN_rsp_rdata valid; rsp_rdata holds its value until the next RESP on that port.
REQ-024 Latency SHALL be fixed: acceptance in cycle T, ACCESS T+1, rsp_valid T+2; next acceptance no earlier than T+3.
REQ-025 pN_grant_cnt SHALL increment on each acceptance of port N and saturate at 16'hFFFF.
REQ-026 Requesters SHALL NOT make req_valid depend on req_ready; a valid dropped before acceptance is simply not served.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, all ready/rsp_valid/strobes 0, rsp_rdata 0, grant counters 0, round-robin pointer to port 0 priority.
REQ-028 Reset asserted during ACCESS SHALL drop mem_write before the next edge; the in-flight access is lost and no response is issued.

Configuration
REQ-029 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous valid, the port not granted last wins; pointer updates on each acceptance.
REQ-030 Without DMEM_ARB_RR_EN, port 0 SHALL always win simultaneous requests (fixed priority); port 1 served only when p0_req_valid low in IDLE.

Verification
REQ-031 p0 write addr 16 data 20 at T -> mem_write=1, mem_address=16, mem_write_data=20 at T+1; p0_rsp_valid=1, p0_rsp_rdata=0 at T+2.
REQ-032 p1 read addr 16 after REQ-031 -> mem_read=1 at T+1, p1_rsp_valid=1 with p1_rsp_rdata=20 at T+2, p0_rsp_valid stays 0.
REQ-033 Both ports valid continuously for 6 grants with DMEM_ARB_RR_EN -> grant order 0,1,0,1,0,1, counters 3/3; without macro -> six port-0 grants, p1_grant_cnt=0.
REQ-034 Assert rst_n=0 mid-ACCESS of write addr 32 data 22 -> mem_write falls before edge, memory addr 32 unchanged, no rsp_valid, busy=0.
REQ-035 Force p0_grant_cnt to 16'hFFFE, issue 3 p0 requests -> counter reads 16'hFFFF and stays.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: IDLE/ACCESS/RESP with fixed latency.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_BUS_WIDTH = 13,
    parameter int DATABUS_SIZE   = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      p0_req_valid,
    input  logic                      p0_req_we,
    input  logic [ADDR_BUS_WIDTH-1:0] p0_req_addr,
    input  logic [DATABUS_SIZE-1:0]   p0_req_wdata,
    output logic                      p0_req_ready,
    output logic                      p0_rsp_valid,
    output logic [DATABUS_SIZE-1:0]   p0_rsp_rdata,
    input  logic                      p1_req_valid,
    input  logic                      p1_req_we,
    input  logic [ADDR_BUS_WIDTH-1:0] p1_req_addr,
    input  logic [DATABUS_SIZE-1:0]   p1_req_wdata,
    output logic                      p1_req_ready,
    output logic                      p1_rsp_valid,
    output logic [DATABUS_SIZE-1:0]   p1_rsp_rdata,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_BUS_WIDTH-1:0] mem_address,
    output logic [DATABUS_SIZE-1:0]   mem_write_data,
    input  logic [DATABUS_SIZE-1:0]   mem_read_data,
    output logic                      busy,
    output logic [15:0]               p0_grant_cnt,
    output logic [15:0]               p1_grant_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                    state_r;
    logic                      port_r;
    logic                      we_r;
    logic [ADDR_BUS_WIDTH-1:0] addr_r;
    logic [DATABUS_SIZE-1:0]   wdata_r;
    logic [DATABUS_SIZE-1:0]   p0_rdata_r;
    logic [DATABUS_SIZE-1:0]   p1_rdata_r;
    logic                      p0_rsp_r;
    logic                      p1_rsp_r;
    logic                      mem_read_r;
    logic                      mem_write_r;
    logic                      busy_r;
    logic [15:0]               p0_cnt_r;
    logic [15:0]               p1_cnt_r;

    logic                      winner_s;
    logic                      accept_s;
    logic                      sel_we_s;
    logic [ADDR_BUS_WIDTH-1:0] sel_addr_s;
    logic [DATABUS_SIZE-1:0]   sel_wdata_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

`ifdef DMEM_ARB_RR_EN
    logic prio_r;

    // Round-robin pointer: the port that lost the last acceptance gets priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (accept_s) begin
            prio_r <= ~winner_s;
        end
    end
`endif

    // Winner selection among pending requests.
    always_comb begin
        winner_s = 1'b0;
        if (p0_req_valid && p1_req_valid) begin
`ifdef DMEM_ARB_RR_EN
            winner_s = prio_r;
`else
            winner_s = 1'b0;
`endif
        end else if (p1_req_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Request fields of the winning port.
    always_comb begin
        sel_we_s    = p0_req_we;
        sel_addr_s  = p0_req_addr;
        sel_wdata_s = p0_req_wdata;
        if (winner_s) begin
            sel_we_s    = p1_req_we;
            sel_addr_s  = p1_req_addr;
            sel_wdata_s = p1_req_wdata;
        end else begin
            sel_we_s    = p0_req_we;
            sel_addr_s  = p0_req_addr;
            sel_wdata_s = p0_req_wdata;
        end
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign accept_s     = rst_n && (state_r == IDLE) && (p0_req_valid || p1_req_valid);
    assign p0_req_ready = accept_s && !winner_s;
    assign p1_req_ready = accept_s && winner_s;

    // Main FSM: latch the winner, drive one memory cycle, then pulse the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            port_r      <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_BUS_WIDTH{1'b0}};
            wdata_r     <= {DATABUS_SIZE{1'b0}};
            p0_rdata_r  <= {DATABUS_SIZE{1'b0}};
            p1_rdata_r  <= {DATABUS_SIZE{1'b0}};
            p0_rsp_r    <= 1'b0;
            p1_rsp_r    <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    p0_rsp_r <= 1'b0;
                    p1_rsp_r <= 1'b0;
                    if (accept_s) begin
                        state_r     <= ACCESS;
                        port_r      <= winner_s;
                        we_r        <= sel_we_s;
                        addr_r      <= sel_addr_s;
                        wdata_r     <= sel_wdata_s;
                        mem_write_r <= sel_we_s;
                        mem_read_r  <= ~sel_we_s;
                        busy_r      <= 1'b1;
                    end
                end
                ACCESS: begin
                    state_r     <= RESP;
                    mem_write_r <= 1'b0;
                    mem_read_r  <= 1'b0;
                    if (port_r) begin
                        p1_rsp_r   <= 1'b1;
                        p1_rdata_r <= we_r ? {DATABUS_SIZE{1'b0}} : mem_read_data;
                    end else begin
                        p0_rsp_r   <= 1'b1;
                        p0_rdata_r <= we_r ? {DATABUS_SIZE{1'b0}} : mem_read_data;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    p0_rsp_r <= 1'b0;
                    p1_rsp_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    p0_rsp_r    <= 1'b0;
                    p1_rsp_r    <= 1'b0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Saturating per-port acceptance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_cnt_r <= 16'd0;
            p1_cnt_r <= 16'd0;
        end else if (accept_s) begin
            if (winner_s) begin
                p1_cnt_r <= sat_inc(p1_cnt_r);
            end else begin
                p0_cnt_r <= sat_inc(p0_cnt_r);
            end
        end
    end

    assign p0_rsp_valid   = p0_rsp_r;
    assign p1_rsp_valid   = p1_rsp_r;
    assign p0_rsp_rdata   = p0_rdata_r;
    assign p1_rsp_rdata   = p1_rdata_r;
    assign mem_read       = mem_read_r;
    assign mem_write      = mem_write_r;
    assign mem_address    = addr_r;
    assign mem_write_data = wdata_r;
    assign busy           = busy_r;
    assign p0_grant_cnt   = p0_cnt_r;
    assign p1_grant_cnt   = p1_cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a latency model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req_valid = 1'b0, p0_req_we = 1'b0;
    logic [12:0] p0_req_addr = 13'd0;
    logic [23:0] p0_req_wdata = 24'd0;
    logic        p0_req_ready, p0_rsp_valid;
    logic [23:0] p0_rsp_rdata;
    logic        p1_req_valid = 1'b0, p1_req_we = 1'b0;
    logic [12:0] p1_req_addr = 13'd0;
    logic [23:0] p1_req_wdata = 24'd0;
    logic        p1_req_ready, p1_rsp_valid;
    logic [23:0] p1_rsp_rdata;
    logic        mem_read, mem_write, busy;
    logic [12:0] mem_address;
    logic [23:0] mem_write_data, mem_read_data;
    logic [15:0] p0_grant_cnt, p1_grant_cnt;

    int total = 0;
    int bad = 0;

    // bench-owned memory
    logic [23:0] mem [0:8191];
    logic        clr = 1'b0, pre_en = 1'b0;
    logic [12:0] pre_addr = 13'd0;
    logic [23:0] pre_data = 24'd0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_rdata(p1_rsp_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy), .p0_grant_cnt(p0_grant_cnt), .p1_grant_cnt(p1_grant_cnt)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 24'd0;
        end else if (mem_write) begin
            mem[mem_address] <= mem_write_data;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end
    end

    // reference model state
    int          age;
    logic        last_win;
    logic        cur_p, cur_we;
    logic [12:0] cur_a;
    logic [23:0] cur_d;
    logic [23:0] ref_mem [0:63];
    logic [23:0] exp_rd [2];
    logic [15:0] exp_cnt [2];
    logic        q_v [2], q_we [2];
    logic [12:0] q_a [2];
    logic [23:0] q_d [2];
    int          gap [2];
    logic        exp_acc, exp_win;
    logic [1:0]  order [6];
    int          grants;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clr = 1'b1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clr = 1'b1;
        p0_req_valid = 1'b1;
        p1_req_valid = 1'b1;
        #1;
        total++;
        if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b%b exp=00", p0_req_ready, p1_req_ready);
        end
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({p0_rsp_valid, p1_rsp_valid, mem_read, mem_write, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000", {p0_rsp_valid, p1_rsp_valid, mem_read, mem_write, busy});
        end
        total++;
        if (p0_grant_cnt !== 16'd0 || p1_grant_cnt !== 16'd0 || p0_rsp_rdata !== 24'd0 || p1_rsp_rdata !== 24'd0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", p0_grant_cnt, p1_grant_cnt, p0_rsp_rdata, p1_rsp_rdata);
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        clr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int w;
        age = 3;
        last_win = 1'b1;
        for (int p = 0; p < 2; p++) begin
            q_v[p] = 1'b0; gap[p] = 0; exp_rd[p] = 24'd0; exp_cnt[p] = 16'd0;
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = 24'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!q_v[p]) begin
                    if (gap[p] > 0) gap[p]--;
                    else begin
                        q_v[p] = 1'b1;
                        q_we[p] = 1'($urandom_range(0, 1));
                        q_a[p] = 13'($urandom_range(0, 63));
                        q_d[p] = 24'($urandom);
                    end
                end
            end
            p0_req_valid = q_v[0]; p0_req_we = q_we[0]; p0_req_addr = q_a[0]; p0_req_wdata = q_d[0];
            p1_req_valid = q_v[1]; p1_req_we = q_we[1]; p1_req_addr = q_a[1]; p1_req_wdata = q_d[1];
            #1;
            exp_acc = (age >= 3) && (q_v[0] || q_v[1]);
            if (q_v[0] && q_v[1]) exp_win = RR ? ~last_win : 1'b0;
            else exp_win = q_v[1];
            total++;
            if (p0_req_ready !== (exp_acc && !exp_win) || p1_req_ready !== (exp_acc && exp_win)) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", cyc, p0_req_ready, p1_req_ready,
                                exp_acc && !exp_win, exp_acc && exp_win);
            end
            total++;
            if (mem_write !== (age == 1 && cur_we) || mem_read !== (age == 1 && !cur_we) || busy !== (age == 1 || age == 2)) begin
                bad++; $display("FAIL rnd_strobe cyc=%0d got w%b r%b b%b age=%0d", cyc, mem_write, mem_read, busy, age);
            end
            if (age == 1) begin
                total++;
                if (mem_address !== cur_a || (cur_we && mem_write_data !== cur_d)) begin
                    bad++; $display("FAIL rnd_mem cyc=%0d got=%h/%h exp=%h/%h", cyc, mem_address, mem_write_data, cur_a, cur_d);
                end
            end
            total++;
            if (p0_rsp_valid !== (age == 2 && !cur_p) || p1_rsp_valid !== (age == 2 && cur_p)) begin
                bad++; $display("FAIL rnd_rsp cyc=%0d got=%b%b age=%0d port=%b", cyc, p0_rsp_valid, p1_rsp_valid, age, cur_p);
            end
            total++;
            if (p0_rsp_rdata !== exp_rd[0] || p1_rsp_rdata !== exp_rd[1]) begin
                bad++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, p0_rsp_rdata, p1_rsp_rdata, exp_rd[0], exp_rd[1]);
            end
            total++;
            if (p0_grant_cnt !== exp_cnt[0] || p1_grant_cnt !== exp_cnt[1]) begin
                bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, p0_grant_cnt, p1_grant_cnt, exp_cnt[0], exp_cnt[1]);
            end
            if (age == 1) begin
                exp_rd[cur_p] = cur_we ? 24'd0 : ref_mem[cur_a[5:0]];
                if (cur_we) ref_mem[cur_a[5:0]] = cur_d;
            end
            if (exp_acc) begin
                w = int'(exp_win);
                cur_p = exp_win; cur_we = q_we[w]; cur_a = q_a[w]; cur_d = q_d[w];
                if (exp_cnt[w] != 16'hFFFF) exp_cnt[w] = exp_cnt[w] + 16'd1;
                last_win = exp_win;
                q_v[w] = 1'b0;
                gap[w] = $urandom_range(0, 3);
                age = 1;
            end else if (age < 3) begin
                age++;
            end
        end
        @(negedge clk);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 13'd16; p0_req_wdata = 24'd20;
        #1;
        total++;
        if (p0_req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", p0_req_ready); end
        @(negedge clk);
        p0_req_valid = 1'b0; p0_req_addr = 13'h1FFF; p0_req_wdata = 24'hFFFFFF;
        #1;
        total++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 13'd16 || mem_write_data !== 24'd20) begin
            bad++; $display("FAIL wr_access got=w%b r%b a%0d d%0d exp=w1 r0 a16 d20", mem_write, mem_read, mem_address, mem_write_data);
        end
        @(negedge clk);
        #1;
        total++;
        if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 24'd0 || p1_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL wr_rsp got=v%b d%0d v1=%b exp=v1 d0 v1=0", p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid);
        end
        @(negedge clk);
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 13'd16;
        #1;
        total++;
        if (p1_req_ready !== 1'b1 || p0_req_ready !== 1'b0) begin
            bad++; $display("FAIL rd_ready got=%b%b exp=01", p0_req_ready, p1_req_ready);
        end
        @(negedge clk);
        p1_req_valid = 1'b0; p1_req_addr = 13'd5;
        #1;
        total++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 13'd16) begin
            bad++; $display("FAIL rd_access got=r%b w%b a%0d exp=r1 w0 a16", mem_read, mem_write, mem_address);
        end
        @(negedge clk);
        #1;
        total++;
        if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== 24'd20 || p0_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rd_rsp got=v%b d%0d v0=%b exp=v1 d20 v0=0", p1_rsp_valid, p1_rsp_rdata, p0_rsp_valid);
        end
        @(negedge clk);
        #1;
        total++;
        if (p1_rsp_valid !== 1'b0 || p1_rsp_rdata !== 24'd20) begin
            bad++; $display("FAIL rd_hold got=v%b d%0d exp=v0 d20", p1_rsp_valid, p1_rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        apply_reset();
        p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 13'd1;
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 13'd2;
        grants = 0;
        cyc = 0;
        while (grants < 6 && cyc < 40) begin
            #1;
            if (p0_req_ready && p1_req_ready) begin
                total++; bad++; $display("FAIL b2b_both_ready cyc=%0d got=11 exp=one-hot", cyc);
            end
            if (p0_req_ready) begin order[grants] = 2'd0; grants++; end
            else if (p1_req_ready) begin order[grants] = 2'd1; grants++; end
            @(negedge clk);
            cyc++;
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        total++;
        if (grants != 6) begin bad++; $display("FAIL b2b_timeout got=%0d exp=6", grants); end
        for (int i = 0; i < grants; i++) begin
            total++;
            if (order[i] !== (RR ? 2'(i % 2) : 2'd0)) begin
                bad++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", i, order[i], RR ? i % 2 : 0);
            end
        end
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (p0_grant_cnt !== (RR ? 16'd3 : 16'd6) || p1_grant_cnt !== (RR ? 16'd3 : 16'd0)) begin
            bad++; $display("FAIL b2b_cnt got=%0d/%0d exp=%0d/%0d", p0_grant_cnt, p1_grant_cnt, RR ? 3 : 6, RR ? 3 : 0);
        end
    endtask

    task automatic test_saturation();
        int waitc;
        apply_reset();
        @(negedge clk);
        force dut.p0_cnt_r = 16'hFFFE;
        #1;
        release dut.p0_cnt_r;
        #1;
        total++;
        if (p0_grant_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_preset got=%h exp=fffe", p0_grant_cnt); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 13'(k);
            waitc = 0;
            #1;
            while (!p0_req_ready && waitc < 10) begin
                @(negedge clk); #1; waitc++;
            end
            total++;
            if (!p0_req_ready) begin bad++; $display("FAIL sat_accept req=%0d got=0 exp=1", k); end
            @(negedge clk);
            p0_req_valid = 1'b0;
            repeat (2) @(negedge clk);
            #1;
            total++;
            if (p0_grant_cnt !== 16'hFFFF || p1_grant_cnt !== 16'd0) begin
                bad++; $display("FAIL sat_cnt req=%0d got=%h/%h exp=ffff/0000", k, p0_grant_cnt, p1_grant_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        @(negedge clk);
        pre_en = 1'b1; pre_addr = 13'd32; pre_data = 24'h5A5A5A;
        @(negedge clk);
        pre_en = 1'b0;
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 13'd32; p0_req_wdata = 24'd22;
        @(negedge clk);
        p0_req_valid = 1'b0;
        #1;
        total++;
        if (mem_write !== 1'b1) begin bad++; $display("FAIL mid_pre_write got=%b exp=1", mem_write); end
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_write !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_drop got=w%b b%b exp=w0 b0", mem_write, busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (mem[32] !== 24'h5A5A5A) begin bad++; $display("FAIL mid_mem got=%h exp=5a5a5a", mem[32]); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL mid_no_rsp cyc=%0d got=%b%b b%b exp=00 b0", i, p0_rsp_valid, p1_rsp_valid, busy);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_random();
        test_write_read();
        test_back_to_back();
        test_saturation();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
